cache_lane_select: RTL and testbench

// - Data-cache read-lane extractor. Takes one 128-bit cache block plus the byte offset of a

---
 rtl/cache_lane_select.sv | 114 +++++++++++
 tb/tb_cache_lane_select.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_lane_select.sv
// Data-cache read-lane extractor: registered byte/half/word lanes and RISC-V load result.
// Optional misalignment check enabled by defining LANE_SELECT_MISALIGN_CHK_EN.
module cache_lane_select #(
   parameter int unsigned WORDSIZE  = 32,
   parameter int unsigned BLOCKSIZE = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [BLOCKSIZE-1:0]  block_i,
   input  logic [3:0]            byte_off_i,
   input  logic [2:0]            funct3_i,
   output logic                  valid_o,
   output logic [WORDSIZE/4-1:0] byte_o,
   output logic [WORDSIZE/2-1:0] half_o,
   output logic [WORDSIZE-1:0]   word_o,
   output logic [WORDSIZE-1:0]   load_o,
   output logic                  err_o,
   output logic                  misalign_o
);

   localparam int unsigned ByteW = WORDSIZE / 4;
   localparam int unsigned HalfW = WORDSIZE / 2;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;

   if (BLOCKSIZE != 4 * WORDSIZE) begin : g_bad_cfg
      $error("cache_lane_select: BLOCKSIZE must equal 4*WORDSIZE");
   end

   logic [ByteW-1:0]    byte_d, byte_q;
   logic [HalfW-1:0]    half_d, half_q;
   logic [WORDSIZE-1:0] word_d, word_q;
   logic [WORDSIZE-1:0] load_d, load_q;
   logic                err_d, err_q;
   logic                valid_q;

   // Lane muxes: 16:1 byte, 8:1 half, 4:1 word; low offset bits truncate the wider lanes.
   always_comb begin
      byte_d = block_i[ByteW*byte_off_i +: ByteW];
      half_d = block_i[HalfW*byte_off_i[3:1] +: HalfW];
      word_d = block_i[WORDSIZE*byte_off_i[3:2] +: WORDSIZE];
   end

   always_comb begin
      load_d = '0;
      err_d  = 1'b0;
      case (funct3_i)
         F3Lb:    load_d = {{(WORDSIZE-ByteW){byte_d[ByteW-1]}}, byte_d};
         F3Lh:    load_d = {{(WORDSIZE-HalfW){half_d[HalfW-1]}}, half_d};
         F3Lw:    load_d = word_d;
         F3Lbu:   load_d = {{(WORDSIZE-ByteW){1'b0}}, byte_d};
         F3Lhu:   load_d = {{(WORDSIZE-HalfW){1'b0}}, half_d};
         default: err_d  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         byte_q  <= '0;
         half_q  <= '0;
         word_q  <= '0;
         load_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            byte_q <= byte_d;
            half_q <= half_d;
            word_q <= word_d;
            load_q <= load_d;
            err_q  <= err_d;
         end
      end
   end

`ifdef LANE_SELECT_MISALIGN_CHK_EN
   logic misalign_d, misalign_q;

   always_comb begin
      misalign_d = 1'b0;
      if ((funct3_i == F3Lh || funct3_i == F3Lhu) && byte_off_i[0]) begin
         misalign_d = 1'b1;
      end else if (funct3_i == F3Lw && byte_off_i[1:0] != 2'b00) begin
         misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else if (valid_i) begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

   assign valid_o = valid_q;
   assign byte_o  = byte_q;
   assign half_o  = half_q;
   assign word_o  = word_q;
   assign load_o  = load_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_cache_lane_select.sv
// Self-checking bench for cache_lane_select: directed cases plus randomized requests
// checked against a byte-array reference model. Honours LANE_SELECT_MISALIGN_CHK_EN.
module tb_cache_lane_select;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid_i;
   logic [127:0] block_i;
   logic [3:0]   byte_off_i;
   logic [2:0]   funct3_i;
   logic         valid_o;
   logic [7:0]   byte_o;
   logic [15:0]  half_o;
   logic [31:0]  word_o;
   logic [31:0]  load_o;
   logic         err_o;
   logic         misalign_o;

   int checks   = 0;
   int failures = 0;

   // Reference model state (what the outputs should read after the last edge)
   logic        m_valid;
   logic [7:0]  m_byte;
   logic [15:0] m_half;
   logic [31:0] m_word;
   logic [31:0] m_load;
   logic        m_err;
   logic        m_mis;

   logic [127:0] test_blk;
   logic [127:0] blk;

   cache_lane_select #(
      .WORDSIZE  (32),
      .BLOCKSIZE (128)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid_i),
      .block_i    (block_i),
      .byte_off_i (byte_off_i),
      .funct3_i   (funct3_i),
      .valid_o    (valid_o),
      .byte_o     (byte_o),
      .half_o     (half_o),
      .word_o     (word_o),
      .load_o     (load_o),
      .err_o      (err_o),
      .misalign_o (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_byte  = '0;
      m_half  = '0;
      m_word  = '0;
      m_load  = '0;
      m_err   = 1'b0;
      m_mis   = 1'b0;
   endtask

   // Load semantics from the byte view of the block, using integer arithmetic for extension.
   task automatic model_capture(input logic [127:0] b, input int off, input int f3);
      logic [7:0] bytes [16];
      int hb, wb, v;
      for (int k = 0; k < 16; k++) bytes[k] = b[k*8 +: 8];
      hb = (off / 2) * 2;
      wb = (off / 4) * 4;
      m_byte = bytes[off];
      m_half = {bytes[hb+1], bytes[hb]};
      m_word = {bytes[wb+3], bytes[wb+2], bytes[wb+1], bytes[wb]};
      m_err  = 1'b0;
      m_mis  = 1'b0;
      case (f3)
         0: begin v = int'(m_byte); if (v >= 128) v = v - 256; m_load = 32'(v); end
         1: begin v = int'(m_half); if (v >= 32768) v = v - 65536; m_load = 32'(v); end
         2: m_load = m_word;
         4: m_load = 32'(int'(m_byte));
         5: m_load = 32'(int'(m_half));
         default: begin m_load = 32'h0; m_err = 1'b1; end
      endcase
`ifdef LANE_SELECT_MISALIGN_CHK_EN
      if ((f3 == 1 || f3 == 5) && (off % 2) != 0) m_mis = 1'b1;
      if (f3 == 2 && (off % 4) != 0) m_mis = 1'b1;
`endif
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
      check_eq({tag, ".byte"}, 32'(byte_o), 32'(m_byte));
      check_eq({tag, ".half"}, 32'(half_o), 32'(m_half));
      check_eq({tag, ".word"}, word_o, m_word);
      check_eq({tag, ".load"}, load_o, m_load);
      check_eq({tag, ".err"}, 32'(err_o), 32'(m_err));
      check_eq({tag, ".misalign"}, 32'(misalign_o), 32'(m_mis));
   endtask

   task automatic step(input string tag, input logic v, input logic [127:0] b,
                       input logic [3:0] off, input logic [2:0] f3);
      @(negedge clk);
      valid_i    = v;
      block_i    = b;
      byte_off_i = off;
      funct3_i   = f3;
      @(posedge clk);
      m_valid = v;
      if (v) model_capture(b, int'(off), int'(f3));
      #1;
      compare_all(tag);
   endtask

   initial begin
      test_blk   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      rst_n      = 1'b0;
      valid_i    = 1'b0;
      block_i    = '0;
      byte_off_i = '0;
      funct3_i   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step("lb_off5", 1'b1, test_blk, 4'd5, 3'b000);
      check_eq("lb_off5_const", load_o, 32'h00000005);
      step("lh_off6", 1'b1, test_blk, 4'd6, 3'b001);
      check_eq("lh_off6_const", load_o, 32'h00000706);
      step("lw_off12", 1'b1, test_blk, 4'd12, 3'b010);
      check_eq("lw_off12_const", word_o, 32'h0F0E0D0C);

      blk = test_blk;
      blk[31:24] = 8'h83;
      step("lb_neg", 1'b1, blk, 4'd3, 3'b000);
      check_eq("lb_neg_const", load_o, 32'hFFFFFF83);
      step("lbu_83", 1'b1, blk, 4'd3, 3'b100);
      check_eq("lbu_83_const", load_o, 32'h00000083);
      blk = test_blk;
      blk[63:56] = 8'h80;
      step("lh_neg", 1'b1, blk, 4'd6, 3'b001);
      check_eq("lh_neg_const", load_o, 32'hFFFF8006);
      step("lhu_8006", 1'b1, blk, 4'd7, 3'b101);

      step("illegal", 1'b1, test_blk, 4'd9, 3'b011);
      check_eq("illegal_err", 32'(err_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step("hold", 1'b0, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 3'b000);
      end
      check_eq("hold_load", load_o, 32'h0);
      step("illegal110", 1'b1, test_blk, 4'd1, 3'b110);
      step("illegal111", 1'b1, test_blk, 4'd2, 3'b111);

      // Asynchronous reset pulse while valid_o is high
      step("pre_rst", 1'b1, test_blk, 4'd15, 3'b010);
      @(negedge clk);
      valid_i = 1'b0;
      rst_n   = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      compare_all("post_rst_idle");
      step("post_rst_lb", 1'b1, test_blk, 4'd5, 3'b000);
      check_eq("post_rst_lb_const", 32'(byte_o), 32'h05);

      step("mis_lw2", 1'b1, test_blk, 4'd2, 3'b010);
      check_eq("mis_lw2_word", word_o, 32'h03020100);
`ifdef LANE_SELECT_MISALIGN_CHK_EN
      check_eq("mis_lw2_flag", 32'(misalign_o), 32'd1);
`else
      check_eq("mis_lw2_flag", 32'(misalign_o), 32'd0);
`endif
      step("mis_lh1", 1'b1, test_blk, 4'd1, 3'b001);
      step("mis_lhu3", 1'b1, test_blk, 4'd3, 3'b101);
      step("mis_lw4", 1'b1, test_blk, 4'd4, 3'b010);

      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom},
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
